ir_command_scheduler: RTL and testbench
=======================================

# ir_command_scheduler

Arbitrates between two command sources and sequences the shared Sony-SIRC IR transmitter that drives the robot.
- Source 1 (manual/override) has fixed priority over source 0 (autonomous planner).
- Each accepted command is held on the transmitter's address/command inputs with transmit asserted for a programmed number of 45 ms frames.
- A mandatory low gap follows each command so the transmitter returns to idle before the next one.
- Sits between the navigation/UI logic and `ir_transmitter`.

## Interface
Parameters:
- FRAME_CYCLES, 1215000: clk cycles per SIRC frame (45 ms at 27 MHz).
- GAP_CYCLES, 810000: transmit-low cycles after each command (30 ms). Must exceed the transmitter's maximum inter-frame wait of 28.2 ms.
- PREEMPT, 1: when 1, a pending source-1 request cuts a source-0 command short at a frame boundary.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  per-source request valid; bit 1 = manual, bit 0 = autonomous.
- req_ready  out  2  per-source accept; a transfer happens on a cycle with valid & ready.
- req0_data  in  16  {repeats[3:0], address[4:0], command[6:0]}.
- req1_data  in  16  same format as req0_data.
- ir_address  out  5  to transmitter address.
- ir_command  out  7  to transmitter command.
- ir_transmit  out  1  to transmitter transmit.
- busy  out  1  high whenever state ≠ IDLE.
- active_src  out  1  source of the current/last grant.
- done  out  2  one-cycle pulse per source when its command finishes or is aborted.
- aborted  out  1  valid with done[0]; 1 = command was preempted.

## Operation
States:
- IDLE: ir_transmit=0.
  - req_ready[1]=1.
  - req_ready[0]=!req_valid[1].
  - On a transfer: latch data and source into registers, load reps_left = (repeats==0 ? 1 : repeats), clear frame_cnt, go to SEND.
- SEND: ir_transmit=1; ir_address/ir_command come from the latched registers and stay stable for the whole state.
  - frame_cnt counts 0..FRAME_CYCLES-1, then wraps.
  - On wrap, reps_left decrements. When frame_cnt==FRAME_CYCLES-1 and reps_left==1, go to GAP and pulse done[src] with aborted=0.
  - Preempt: if PREEMPT, src==0, req_valid[1]=1, frame_cnt==FRAME_CYCLES-1 and reps_left>1, go to GAP and pulse done[0] with aborted=1.
  - req_ready=0 throughout SEND.
- GAP: ir_transmit=0; ir_address/ir_command hold their values; a counter runs GAP_CYCLES cycles, then the state returns to IDLE. req_ready=0.

General rules:
- No queueing. Requesters hold valid until accepted. A source-0 request while source 1 is valid stays pending.
- Simultaneous valid on both sources in IDLE: source 1 is granted.
- req_valid dropping during SEND or GAP has no effect on the command in progress.
- reset mid-operation: return to IDLE immediately. The next cycle has ir_transmit=0, so the transmitter abandons the frame at its next wait expiry.

## Timing
- Reset values: state IDLE, ir_transmit 0, ir_address 0, ir_command 0, busy 0, active_src 0, done 00, aborted 0, req_ready 11 (source 0 ready only while req_valid[1]=0).
- Outputs are registered, except req_ready, which is combinational from state and req_valid.
- Accept at cycle T: ir_transmit=1 and the new address/command appear at T+1.
- SEND lasts exactly reps×FRAME_CYCLES cycles, or k×FRAME_CYCLES cycles if preempted after k frames.
- done is registered and coincides with the first GAP cycle.
- GAP lasts exactly GAP_CYCLES cycles. The earliest next accept is the first IDLE cycle.
- Back-to-back period = 1 + reps×FRAME_CYCLES + GAP_CYCLES cycles.
- Counter widths: $clog2(FRAME_CYCLES) and $clog2(GAP_CYCLES); reps_left is 4 bits.

## Structure
- Shared package `ir_pkg`:
  - state encoding (IDLE/SEND/GAP);
  - field positions of the 16-bit request word;
  - SRC_AUTO=0, SRC_MANUAL=1;
  - default FRAME_CYCLES and GAP_CYCLES for 27 MHz.
- Optional sub-module `ir_req_arbiter`: combinational fixed-priority grant and ready generation. The counters and FSM stay in the top module.
- The top module is intended to instantiate `ir_transmitter` externally. This block does not embed it.

## Test plan
All scenarios use FRAME_CYCLES=100, GAP_CYCLES=20.
- Single command: source 0 sends repeats=3, addr=5'h01, cmd=7'h12 → ir_transmit high for exactly 300 cycles starting one cycle after accept; outputs stable at 01/12; done[0] pulses at cycle 301 after accept, aborted=0; busy low 20 cycles later.
- repeats=0 → identical to repeats=1: transmit high for 100 cycles.
- Simultaneous requests in IDLE (src0 cmd 7'h05, src1 cmd 7'h7F) → src1 granted first (ir_command=7'h7F, active_src=1); src0 held not ready until src1 completes its SEND and GAP; src0 served on the next IDLE cycle.
- Preemption: src0 sends repeats=5; src1 raises valid at cycle 150 → src0's SEND ends at cycle 200 (two frames); done[0] and aborted=1 pulse; after the 20-cycle GAP, src1 is accepted. Repeat with PREEMPT=0 → src0 runs all 500 cycles.
- reset asserted at cycle 50 of SEND → the next cycle has ir_transmit=0, busy=0, done=0, req_ready=11.
- Back-to-back src0 commands with valid held high → second accept exactly 1+100+20 cycles after the first.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: shared definitions for the IR command scheduler slice.
//   - FSM state encoding (IDLE/SEND/GAP)
//   - bit positions of the 16-bit request word {repeats[3:0], address[4:0], command[6:0]}
//   - source identifiers and default 27 MHz timing
//   - helper that turns a requested repeat count into the frame count to send
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int REQ_W    = 16;
  localparam int REPS_LSB = 12;
  localparam int REPS_W   = 4;
  localparam int ADDR_LSB = 7;
  localparam int ADDR_W   = 5;
  localparam int CMD_LSB  = 0;
  localparam int CMD_W    = 7;

  localparam logic SRC_AUTO   = 1'b0;
  localparam logic SRC_MANUAL = 1'b1;

  // 45 ms frame and 30 ms gap at 27 MHz
  localparam int DEF_FRAME_CYCLES = 1215000;
  localparam int DEF_GAP_CYCLES   = 810000;

  // A request for zero repeats still sends one frame.
  function automatic logic [REPS_W-1:0] load_reps(input logic [REPS_W-1:0] reps);
    return (reps == '0) ? REPS_W'(1) : reps;
  endfunction

endpackage

// File: rtl/ir_command_scheduler_if.sv
// ir_command_scheduler_if: request bus from the two command sources.
//   req_valid[1:0]  per-source valid (bit 1 manual, bit 0 autonomous)
//   req_ready[1:0]  per-source ready from the scheduler
//   req0_data/req1_data  {repeats[3:0], address[4:0], command[6:0]}
//
// Handshake: a transfer on source s happens on a rising clk edge where
// req_valid[s] && req_ready[s]. A requester raises valid with stable data and
// holds both until that transfer; it must not withdraw data before it. Ready
// may depend combinationally on valid, valid never depends on ready.
interface ir_command_scheduler_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_data;
  logic [15:0] req1_data;

  modport master (output req_valid, output req0_data, output req1_data, input req_ready);
  modport slave  (input req_valid, input req0_data, input req1_data, output req_ready);
endinterface

// File: rtl/ir_req_arbiter.sv
// ir_req_arbiter: combinational fixed-priority grant for the scheduler.
//   i_idle        scheduler is in IDLE and may accept
//   i_valid[1:0]  per-source request valid
//   i_data0/1     request words of source 0 / source 1
//   o_ready[1:0]  per-source ready (manual always ready in IDLE, autonomous
//                 only when manual is not requesting)
//   o_grant       a transfer happens this cycle
//   o_grant_src   source of that transfer
//   o_grant_data  request word of that transfer
module ir_req_arbiter
  import ir_pkg::*;
(
  input  logic        i_idle,
  input  logic [1:0]  i_valid,
  input  logic [15:0] i_data0,
  input  logic [15:0] i_data1,
  output logic [1:0]  o_ready,
  output logic        o_grant,
  output logic        o_grant_src,
  output logic [15:0] o_grant_data
);

  always_comb begin
    o_ready      = 2'b00;
    o_grant      = 1'b0;
    o_grant_src  = SRC_AUTO;
    o_grant_data = i_data0;
    if (i_idle) begin
      o_ready = {1'b1, ~i_valid[SRC_MANUAL]};
      o_grant = |(i_valid & o_ready);
      if (i_valid[SRC_MANUAL]) begin
        o_grant_src  = SRC_MANUAL;
        o_grant_data = i_data1;
      end
    end
  end

endmodule

// File: rtl/ir_command_scheduler.sv
// ir_command_scheduler: arbitrates two command sources onto one Sony-SIRC
// transmitter. An accepted command is held on ir_address/ir_command with
// ir_transmit high for repeats x FRAME_CYCLES cycles, followed by a
// GAP_CYCLES low gap so the transmitter goes idle before the next command.
//   clk, reset    clock, synchronous active-high reset
//   req           request bus (slave side)
//   ir_address    transmitter address
//   ir_command    transmitter command
//   ir_transmit   transmitter enable
//   busy          high whenever not IDLE
//   active_src    source of the current/last grant
//   done[1:0]     one-cycle pulse per source at command end (first GAP cycle)
//   aborted       with done[0]: the command was cut short by source 1
//   dbg_state     current FSM state
module ir_command_scheduler
  import ir_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter bit PREEMPT      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  ir_command_scheduler_if.slave  req,
  output logic [ADDR_W-1:0]      ir_address,
  output logic [CMD_W-1:0]       ir_command,
  output logic                   ir_transmit,
  output logic                   busy,
  output logic                   active_src,
  output logic [1:0]             done,
  output logic                   aborted,
  output state_t                 dbg_state
);

  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  state_t              r_state;
  logic [FW-1:0]       r_frame_cnt;
  logic [GW-1:0]       r_gap_cnt;
  logic [REPS_W-1:0]   r_reps_left;
  logic                r_src;
  logic [ADDR_W-1:0]   r_ir_address;
  logic [CMD_W-1:0]    r_ir_command;
  logic                r_ir_transmit;
  logic                r_busy;
  logic [1:0]          r_done;
  logic                r_aborted;

  logic                w_grant;
  logic                w_grant_src;
  logic [REQ_W-1:0]    w_grant_data;

  ir_req_arbiter u_arb (
    .i_idle       (r_state == ST_IDLE),
    .i_valid      (req.req_valid),
    .i_data0      (req.req0_data),
    .i_data1      (req.req1_data),
    .o_ready      (req.req_ready),
    .o_grant      (w_grant),
    .o_grant_src  (w_grant_src),
    .o_grant_data (w_grant_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_frame_cnt   <= '0;
      r_gap_cnt     <= '0;
      r_reps_left   <= '0;
      r_src         <= SRC_AUTO;
      r_ir_address  <= '0;
      r_ir_command  <= '0;
      r_ir_transmit <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 2'b00;
      r_aborted     <= 1'b0;
    end else begin
      r_done    <= 2'b00;
      r_aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state       <= ST_SEND;
            r_src         <= w_grant_src;
            r_reps_left   <= load_reps(w_grant_data[REPS_LSB +: REPS_W]);
            r_frame_cnt   <= '0;
            r_ir_address  <= w_grant_data[ADDR_LSB +: ADDR_W];
            r_ir_command  <= w_grant_data[CMD_LSB +: CMD_W];
            r_ir_transmit <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        ST_SEND: begin
          if (r_frame_cnt == FRAME_LAST) begin
            r_frame_cnt <= '0;
            r_reps_left <= r_reps_left - REPS_W'(1);
            if (r_reps_left == REPS_W'(1)) begin
              r_state        <= ST_GAP;
              r_gap_cnt      <= '0;
              r_ir_transmit  <= 1'b0;
              r_done[r_src]  <= 1'b1;
            end else if (PREEMPT && (r_src == SRC_AUTO) && req.req_valid[SRC_MANUAL]) begin
              // Manual override cuts the autonomous command at a frame boundary.
              r_state          <= ST_GAP;
              r_gap_cnt        <= '0;
              r_ir_transmit    <= 1'b0;
              r_done[SRC_AUTO] <= 1'b1;
              r_aborted        <= 1'b1;
            end
          end else begin
            r_frame_cnt <= r_frame_cnt + FW'(1);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_ir_transmit <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign ir_address  = r_ir_address;
  assign ir_command  = r_ir_command;
  assign ir_transmit = r_ir_transmit;
  assign busy        = r_busy;
  assign active_src  = r_src;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ir_command_scheduler.sv
// tb_ir_command_scheduler: self-checking bench for ir_command_scheduler with
// FRAME_CYCLES=100, GAP_CYCLES=20. One instance with PREEMPT=1 carries all
// traffic; a second instance with PREEMPT=0 runs the no-preemption sequence.
module tb_ir_command_scheduler;
  import ir_pkg::*;

  localparam int F = 100;
  localparam int G = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  ir_command_scheduler_if rif ();
  ir_command_scheduler_if rif_np ();

  logic [4:0] ir_address, np_ir_address;
  logic [6:0] ir_command, np_ir_command;
  logic       ir_transmit, np_ir_transmit;
  logic       busy, np_busy;
  logic       active_src, np_active_src;
  logic [1:0] done, np_done;
  logic       aborted, np_aborted;
  state_t     dbg_state, np_dbg_state;

  ir_command_scheduler #(.FRAME_CYCLES(F), .GAP_CYCLES(G), .PREEMPT(1'b1)) dut (
    .clk(clk), .reset(reset), .req(rif),
    .ir_address(ir_address), .ir_command(ir_command), .ir_transmit(ir_transmit),
    .busy(busy), .active_src(active_src), .done(done), .aborted(aborted),
    .dbg_state(dbg_state)
  );

  ir_command_scheduler #(.FRAME_CYCLES(F), .GAP_CYCLES(G), .PREEMPT(1'b0)) dut_np (
    .clk(clk), .reset(reset), .req(rif_np),
    .ir_address(np_ir_address), .ir_command(np_ir_command), .ir_transmit(np_ir_transmit),
    .busy(np_busy), .active_src(np_active_src), .done(np_done), .aborted(np_aborted),
    .dbg_state(np_dbg_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mk(input int reps, input int addr, input int cmd);
    return {4'(reps), 5'(addr), 7'(cmd)};
  endfunction

  // ---------------- reference model + scoreboard ----------------
  // Timeline model: a command accepted in cycle t with send length len
  // transmits in cycles t+1..t+len, gaps in t+len+1..t+len+G, and is idle after.
  logic        m_live = 1'b0;
  logic        m_has = 1'b0;
  logic        m_abort = 1'b0;
  int          m_tacc = 0;
  int          m_len = 0;
  int          m_reps = 0;
  logic        m_src = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [6:0]  m_cmd = '0;
  logic [12:0] exp_q[$];
  logic        prev_tx = 1'b0;

  always @(negedge clk) begin : model
    logic        send, gap, idle, e_ab;
    logic [1:0]  v, e_done, e_ready;
    logic [19:0] e_pk, a_pk;
    logic [15:0] d;
    logic [31:0] sb_exp;
    v = rif.req_valid;
    if (reset) begin
      m_live = 1'b1; m_has = 1'b0; m_abort = 1'b0;
      m_src = 1'b0; m_addr = '0; m_cmd = '0;
      exp_q.delete();
      prev_tx = 1'b0;
    end else if (m_live) begin
      send    = m_has && (cyc > m_tacc) && (cyc <= m_tacc + m_len);
      gap     = m_has && (cyc > m_tacc + m_len) && (cyc <= m_tacc + m_len + G);
      idle    = !send && !gap;
      e_done  = (m_has && cyc == m_tacc + m_len + 1) ? (m_src ? 2'b10 : 2'b01) : 2'b00;
      e_ab    = (e_done != 2'b00) && m_abort;
      e_ready = idle ? {1'b1, ~v[1]} : 2'b00;
      e_pk = {send, send | gap, m_addr, m_cmd, m_src, e_done, e_ab, e_ready};
      a_pk = {ir_transmit, busy, ir_address, ir_command, active_src, done, aborted, rif.req_ready};
      check("cycle_model", {12'h0, a_pk}, {12'h0, e_pk});

      if (ir_transmit && !prev_tx) begin
        sb_exp = (exp_q.size() > 0) ? {19'h0, exp_q.pop_front()} : 32'hDEAD_BEEF;
        check("sb_cmd", {19'h0, active_src, ir_address, ir_command}, sb_exp);
      end
      prev_tx = ir_transmit;

      if (send && !m_src && ((cyc - m_tacc) % F == 0) && ((cyc - m_tacc) / F < m_reps) && v[1]) begin
        m_len   = cyc - m_tacc;
        m_abort = 1'b1;
      end

      if (idle && ((v & e_ready) != 2'b00)) begin
        m_src   = v[1];
        d       = m_src ? rif.req1_data : rif.req0_data;
        m_reps  = (d[15:12] == 4'd0) ? 1 : int'(d[15:12]);
        m_len   = m_reps * F;
        m_tacc  = cyc;
        m_has   = 1'b1;
        m_abort = 1'b0;
        m_addr  = d[11:7];
        m_cmd   = d[6:0];
        exp_q.push_back({m_src, m_addr, m_cmd});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Raise valid on source s, hold until accepted, then drop. Returns accept cycle.
  task automatic request(input logic s, input logic [15:0] d, output int t_acc);
    if (s) rif.req1_data = d; else rif.req0_data = d;
    rif.req_valid[s] = 1'b1;
    t_acc = -1;
    for (int n = 0; n < 2000 && t_acc < 0; n++) begin
      @(negedge clk);
      if (rif.req_valid[s] && rif.req_ready[s]) t_acc = cyc;
      step();
    end
    rif.req_valid[s] = 1'b0;
    check("accept_in_budget", {31'h0, (t_acc >= 0)}, 32'h1);
  endtask

  task automatic wait_idle;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy) break;
      step();
    end
    check("idle_in_budget", {31'h0, busy}, 32'h0);
    step();
  endtask

  // Follow one command from the cycle after accept until busy drops.
  task automatic observe(input int t_acc, input logic s, input int exp_len,
                         input logic [4:0] ea, input logic [6:0] ec);
    int first, cnt, done_c, idle_c;
    logic [1:0] dv;
    logic ab, stable;
    first = -1; cnt = 0; done_c = -1; idle_c = -1; dv = 2'b00; ab = 1'b0; stable = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (ir_transmit) begin
        cnt++;
        if (first < 0) first = cyc;
        if (ir_address !== ea || ir_command !== ec) stable = 1'b0;
      end
      if (done != 2'b00 && done_c < 0) begin
        done_c = cyc; dv = done; ab = aborted;
      end
      if (!busy) begin
        idle_c = cyc;
        break;
      end
      step();
    end
    step();
    check("vec_tx_start", first, t_acc + 1);
    check("vec_tx_len", cnt, exp_len);
    check("vec_done_cycle", done_c, t_acc + exp_len + 1);
    check("vec_done_src", {30'h0, dv}, s ? 32'h2 : 32'h1);
    check("vec_aborted", {31'h0, ab}, 32'h0);
    check("vec_busy_low", idle_c, t_acc + exp_len + G + 1);
    check("vec_stable", {31'h0, stable}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic       src;
    int         reps;
    logic [4:0] addr;
    logic [6:0] cmd;
    int         exp_len;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int t, t1, t2, dc, cnt;
    int acc_t[2];
    logic [1:0] dv, acc;
    logic ab;

    vecs[0] = '{1'b0, 3, 5'h01, 7'h12, 300};
    vecs[1] = '{1'b0, 0, 5'h0A, 7'h33, 100};
    vecs[2] = '{1'b1, 2, 5'h1F, 7'h7F, 200};
    vecs[3] = '{1'b1, 1, 5'h10, 7'h55, 100};

    rif.req_valid = 2'b00; rif.req0_data = '0; rif.req1_data = '0;
    rif_np.req_valid = 2'b00; rif_np.req0_data = '0; rif_np.req1_data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_transmit", {31'h0, ir_transmit}, 32'h0);
    check("rst_address", {27'h0, ir_address}, 32'h0);
    check("rst_command", {25'h0, ir_command}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_active_src", {31'h0, active_src}, 32'h0);
    check("rst_done", {30'h0, done}, 32'h0);
    check("rst_aborted", {31'h0, aborted}, 32'h0);
    check("rst_ready", {30'h0, rif.req_ready}, 32'h3);
    check("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    step();

    // table-driven single commands
    foreach (vecs[i]) begin
      request(vecs[i].src, mk(vecs[i].reps, vecs[i].addr, vecs[i].cmd), t);
      observe(t, vecs[i].src, vecs[i].exp_len, vecs[i].addr, vecs[i].cmd);
    end

    // simultaneous requests: manual wins, autonomous waits for SEND+GAP
    rif.req0_data = mk(1, 2, 7'h05);
    rif.req1_data = mk(1, 3, 7'h7F);
    rif.req_valid = 2'b11;
    @(negedge clk);
    check("simul_ready", {30'h0, rif.req_ready}, 32'h2);
    t1 = cyc;
    step();
    rif.req_valid[1] = 1'b0;
    @(negedge clk);
    check("simul_first_cmd", {25'h0, ir_command}, 32'h7F);
    check("simul_first_src", {31'h0, active_src}, 32'h1);
    t2 = -1;
    for (int n = 0; n < 2000; n++) begin
      if (rif.req_ready[0]) begin
        t2 = cyc;
        break;
      end
      step();
      @(negedge clk);
    end
    step();
    rif.req_valid[0] = 1'b0;
    check("simul_second_accept", t2, t1 + 1 + F + G);
    @(negedge clk);
    check("simul_second_cmd", {25'h0, ir_command}, 32'h05);
    check("simul_second_src", {31'h0, active_src}, 32'h0);
    step();
    wait_idle();

    // preemption (PREEMPT=1)
    request(1'b0, mk(5, 4, 7'h21), t);
    while (cyc < t + 150) step();
    rif.req1_data = mk(1, 6, 7'h44);
    rif.req_valid[1] = 1'b1;
    dc = -1; t1 = -1; dv = 2'b00; ab = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done != 2'b00 && dc < 0) begin
        dc = cyc; dv = done; ab = aborted;
      end
      if (rif.req_valid[1] && rif.req_ready[1]) begin
        t1 = cyc;
        break;
      end
      step();
    end
    step();
    rif.req_valid[1] = 1'b0;
    check("preempt_done_cycle", dc, t + 2 * F + 1);
    check("preempt_done_src", {30'h0, dv}, 32'h1);
    check("preempt_aborted", {31'h0, ab}, 32'h1);
    check("preempt_next_accept", t1, t + 2 * F + G + 1);
    wait_idle();

    // same sequence without preemption on the second instance
    rif_np.req0_data = mk(5, 4, 7'h21);
    rif_np.req_valid[0] = 1'b1;
    t = -1;
    for (int n = 0; n < 100 && t < 0; n++) begin
      @(negedge clk);
      if (rif_np.req_ready[0]) t = cyc;
      step();
    end
    rif_np.req_valid[0] = 1'b0;
    cnt = 0; dc = -1; t1 = -1; dv = 2'b00; ab = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (np_ir_transmit) cnt++;
      if (np_done != 2'b00 && dc < 0) begin
        dc = cyc; dv = np_done; ab = np_aborted;
      end
      if (rif_np.req_valid[1] && rif_np.req_ready[1]) begin
        t1 = cyc;
        break;
      end
      step();
      if (cyc == t + 150) begin
        rif_np.req1_data = mk(1, 6, 7'h44);
        rif_np.req_valid[1] = 1'b1;
      end
    end
    step();
    rif_np.req_valid[1] = 1'b0;
    check("nopre_tx_len", cnt, 5 * F);
    check("nopre_done_cycle", dc, t + 5 * F + 1);
    check("nopre_done_src", {30'h0, dv}, 32'h1);
    check("nopre_aborted", {31'h0, ab}, 32'h0);
    check("nopre_next_accept", t1, t + 5 * F + G + 1);
    for (int n = 0; n < 3000 && np_busy; n++) step();

    // reset in the middle of SEND
    request(1'b0, mk(2, 7, 7'h0F), t);
    while (cyc < t + 50) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_transmit", {31'h0, ir_transmit}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {30'h0, done}, 32'h0);
    check("midrst_ready", {30'h0, rif.req_ready}, 32'h3);
    step();

    // back-to-back with valid held
    rif.req0_data = mk(1, 3, 7'h11);
    rif.req_valid[0] = 1'b1;
    acc_t[0] = -1000; acc_t[1] = -1000;
    t = 0;
    for (int n = 0; n < 2000 && t < 2; n++) begin
      @(negedge clk);
      if (rif.req_ready[0]) begin
        acc_t[t] = cyc;
        t++;
      end
      if (t < 2) step();
    end
    step();
    rif.req_valid[0] = 1'b0;
    check("b2b_period", acc_t[1] - acc_t[0], 1 + F + G);
    wait_idle();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = rif.req_valid & rif.req_ready;
      step();
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) rif.req_valid[s] = 1'b0;
        else if (!rif.req_valid[s] && $urandom_range(0, (s == 1) ? 60 : 8) == 0) begin
          if (s == 1) rif.req1_data = mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 127));
          else        rif.req0_data = mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 127));
          rif.req_valid[s] = 1'b1;
        end
      end
    end
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      acc = rif.req_valid & rif.req_ready;
      if (rif.req_valid == 2'b00 && !busy) break;
      step();
      for (int s = 0; s < 2; s++) if (acc[s]) rif.req_valid[s] = 1'b0;
    end
    step();
    check("random_drained", {29'h0, rif.req_valid, busy}, 32'h0);
    check("sb_queue_empty", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
